// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and default width.
package pipe_skid_stage_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_skid_stage_nbit_reg_en.sv
// N-bit register with asynchronous active-high reset to zero and synchronous load enable.
module nbit_reg_en
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer (main M, skid S) and flush.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    state_t       state;
    state_t       state_nx;
    logic         m_en;
    logic         s_en;
    logic [N-1:0] m_d;
    logic [N-1:0] m_q;
    logic [N-1:0] s_q;
    logic         accept;
    logic         emit;

    // Handshake outputs decode only the state register, so no input-to-output path.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = m_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        m_en     = 1'b0;
        s_en     = 1'b0;
        m_d      = in_data;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_en     = 1'b1;
                        state_nx = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        m_en = 1'b1;
                    end else if (accept) begin
                        s_en     = 1'b1;
                        state_nx = ST_FULL;
                    end else if (emit) begin
                        state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        m_d      = s_q;
                        m_en     = 1'b1;
                        state_nx = ST_ONE;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    nbit_reg_en #(.N(N)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (m_en),
        .d   (m_d),
        .q   (m_q)
    );

    nbit_reg_en #(.N(N)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (s_en),
        .d   (in_data),
        .q   (s_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: vector table, corner sequences, random vs queue model.
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int unsigned nvec;
    int unsigned nerr;

    pipe_skid_stage #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] d;
        logic        ov;
        logic        ir;
        logic [31:0] od;
        logic        cd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
    endtask

    // Inputs are changed 1 time unit after the rising edge, outputs sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // Reference model: the stage is a FIFO of depth 2 presenting its head word.
    logic [31:0] q [$];
    logic [31:0] expected_head;

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'hA5, 1'b1, 1'b1, 32'hA5, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h5A, 1'b1, 1'b0, 32'hA5, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'hFF, 1'b1, 1'b0, 32'hA5, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'hFF, 1'b1, 1'b1, 32'h5A, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h5A, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h01, 1'b1, 1'b1, 32'h01, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h02, 1'b1, 1'b1, 32'h02, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 1'b0, 32'h02, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 32'h00, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h44, 1'b1, 1'b1, 32'h44, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h44, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h00, 1'b0};

        // Reset state
        do_reset();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_data", out_data, 32'h0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].d);
            step();
            chk($sformatf("tbl%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
            chk($sformatf("tbl%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].ir});
            if (tbl[i].cd) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
        end

        // Asynchronous reset while FULL
        drive(1'b1, 1'b0, 1'b0, 32'hC1);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'hC2);
        step();
        chk("pre_areset_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("areset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("areset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("areset_out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Streaming, one word per cycle after a one-cycle lag
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b1, 1'b0, k);
            step();
            chk($sformatf("stream%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stream%0d_out_data", k), out_data, k);
            chk($sformatf("stream%0d_in_ready", k), {31'b0, in_ready}, 32'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("stream_drain_out_valid", {31'b0, out_valid}, 32'd0);

        // Stall hold in FULL for 20 cycles with a pending upstream word
        drive(1'b1, 1'b0, 1'b0, 32'hA5);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h5A);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'hFF);
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("stall%0d_out_data", c), out_data, 32'hA5);
            chk($sformatf("stall%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("release_word2", out_data, 32'h5A);
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("release_empty", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with a simultaneous upstream word
        drive(1'b1, 1'b0, 1'b0, 32'h11);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h22);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h33);
        step();
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h44);
        step();
        chk("post_flush_first", out_data, 32'h44);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("post_flush_single", {31'b0, out_valid}, 32'd0);

        // Random traffic against the queue model
        do_reset();
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic iv;
            logic ordy;
            logic fl;
            logic acc;
            logic emt;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            drive(iv, ordy, fl, $urandom);
            acc = iv && (q.size() < 2);
            emt = ordy && (q.size() > 0);
            step();
            if (fl) begin
                q.delete();
            end else begin
                if (emt) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
            nvec++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                nerr++;
                $display("FAIL rand%0d_handshake: got ov=%b ir=%b expected ov=%b ir=%b",
                         c, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                expected_head = q[0];
                chk($sformatf("rand%0d_out_data", c), out_data, expected_head);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
